// File: rtl/fb_scanout_if.sv
// Purpose : frame-buffer write port (GPU side) plus pixel stream (LCD side) for fb_scanout.
// Latency : wires only, no storage.
// Backpressure: pixel stream is valid/ready; the write port has no backpressure.
//
// Ports (signals):
//   iFrameBufferWe/Addr/Data : GPU word writes, 8 pixels of 2 bpp per word
//   iPixelReady              : sink ready
//   oPixel/oPixelValid       : pixel stream towards the panel controller
//   oFirstPixel/oLineEnd     : frame start and row end markers, qualified by oPixelValid
//   oBusy/oFrameDone/oFrameCount : scan status
// modport master = GPU/panel side, modport slave = fb_scanout.
interface fb_scanout_if;
    logic        iFrameBufferWe;
    logic [15:0] iFrameBufferAddr;
    logic [15:0] iFrameBufferData;
    logic        iPixelReady;
    logic [1:0]  oPixel;
    logic        oPixelValid;
    logic        oFirstPixel;
    logic        oLineEnd;
    logic        oBusy;
    logic        oFrameDone;
    logic [7:0]  oFrameCount;

    modport master (
        output iFrameBufferWe, iFrameBufferAddr, iFrameBufferData, iPixelReady,
        input  oPixel, oPixelValid, oFirstPixel, oLineEnd, oBusy, oFrameDone, oFrameCount
    );

    modport slave (
        input  iFrameBufferWe, iFrameBufferAddr, iFrameBufferData, iPixelReady,
        output oPixel, oPixelValid, oFirstPixel, oLineEnd, oBusy, oFrameDone, oFrameCount
    );
endinterface

// File: rtl/fb_scanout.sv
// Purpose : stores GPU frame-buffer words and streams the frame out pixel by pixel after the last word is written.
// Latency : first pixel valid 3 cycles after the frame-complete write; 2-cycle bubble between words.
// Backpressure: oPixel/oPixelValid hold while iPixelReady=0; GPU writes are never stalled.
//
// Ports:
//   iClock, iReset : clock and synchronous active-high reset
//   bus            : fb_scanout_if.slave (write port, pixel stream, status)
// Optional feature macro FB_DOUBLE_BUFFER_EN: two banks, GPU writes the hidden bank,
// scan reads the displayed bank, banks swap when a scan starts.
module fb_scanout #(
    parameter int FB_WORDS      = 8192,
    parameter int WORDS_PER_ROW = 32,
    parameter int ADDR_W        = 13
) (
    input  logic        iClock,
    input  logic        iReset,
    fb_scanout_if.slave bus
);
    localparam int ROW_AW = $clog2(WORDS_PER_ROW);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FB_WORDS - 1);
`ifdef FB_DOUBLE_BUFFER_EN
    localparam int MEM_AW    = ADDR_W + 1;
    localparam int MEM_WORDS = 2 * FB_WORDS;
`else
    localparam int MEM_AW    = ADDR_W;
    localparam int MEM_WORDS = FB_WORDS;
`endif

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, SHIFT} tState;

    tState             state, stateNext;
    logic [15:0]       mem [0:MEM_WORDS-1];
    logic [15:0]       readData;
    logic [15:0]       shiftReg;
    logic [ADDR_W-1:0] wordAddr;
    logic [2:0]        pixIdx;
    logic              pending;
    logic              frameDone;
    logic [7:0]        frameCount;
    logic [MEM_AW-1:0] writeIdx;
    logic [MEM_AW-1:0] readIdx;
    logic              addrInRange;
    logic              frameComplete;
    logic              startScan;
    logic              xfer;
    logic              lastPix;
    logic              lastWord;

    // Any address bit above the word range set means the write is dropped.
    assign addrInRange   = (bus.iFrameBufferAddr >> ADDR_W) == 16'd0;
    assign frameComplete = bus.iFrameBufferWe && (bus.iFrameBufferAddr == 16'(FB_WORDS - 1));
    assign startScan     = (state == IDLE) && (frameComplete || pending);
    assign xfer          = (state == SHIFT) && bus.iPixelReady;
    assign lastPix       = pixIdx == 3'd7;
    assign lastWord      = wordAddr == LAST_WORD;

`ifdef FB_DOUBLE_BUFFER_EN
    logic sel;

    // Swapping on the start cycle makes the bank just written by the
    // frame-complete write the one being displayed.
    assign writeIdx = {~sel, bus.iFrameBufferAddr[ADDR_W-1:0]};
    assign readIdx  = {sel, wordAddr};

    always_ff @(posedge iClock) begin
        if (iReset) begin
            sel <= 1'b0;
        end else if (startScan) begin
            sel <= ~sel;
        end
    end
`else
    assign writeIdx = bus.iFrameBufferAddr[ADDR_W-1:0];
    assign readIdx  = wordAddr;
`endif

    // Contents survive reset. Read and write in one block give read-first
    // behaviour on a same-word collision.
    always_ff @(posedge iClock) begin
        if (bus.iFrameBufferWe && addrInRange) begin
            mem[writeIdx] <= bus.iFrameBufferData;
        end
        readData <= mem[readIdx];
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (startScan) stateNext = FETCH;
            FETCH:   stateNext = LOAD;
            LOAD:    stateNext = SHIFT;
            SHIFT:   if (xfer && lastPix) stateNext = lastWord ? IDLE : FETCH;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            wordAddr   <= '0;
            pixIdx     <= '0;
            shiftReg   <= '0;
            pending    <= 1'b0;
            frameDone  <= 1'b0;
            frameCount <= '0;
        end else begin
            frameDone <= 1'b0;
            // Any number of frame completions during a scan collapse into one rescan.
            if (startScan) begin
                pending  <= 1'b0;
                wordAddr <= '0;
            end else if (frameComplete) begin
                pending <= 1'b1;
            end
            if (state == LOAD) begin
                shiftReg <= readData;
                pixIdx   <= '0;
            end
            if (xfer) begin
                shiftReg <= {shiftReg[13:0], 2'b00};
                pixIdx   <= pixIdx + 3'd1;
                if (lastPix) begin
                    if (lastWord) begin
                        frameDone  <= 1'b1;
                        frameCount <= frameCount + 8'd1;
                    end else begin
                        wordAddr <= wordAddr + ADDR_W'(1);
                    end
                end
            end
        end
    end

    assign bus.oPixelValid = state == SHIFT;
    assign bus.oPixel      = shiftReg[15:14];
    assign bus.oFirstPixel = bus.oPixelValid && (wordAddr == '0) && (pixIdx == 3'd0);
    assign bus.oLineEnd    = bus.oPixelValid && (&wordAddr[ROW_AW-1:0]) && lastPix;
    assign bus.oBusy       = state != IDLE;
    assign bus.oFrameDone  = frameDone;
    assign bus.oFrameCount = frameCount;
endmodule

// File: tb/tb_fb_scanout.sv
// Purpose : randomized bench for fb_scanout against a frame-level reference model.
// Latency : model expects the first pixel 3 cycles after a frame-complete write.
// Backpressure: sink ready is driven always-on, toggling or random.
module tb_fb_scanout;
    localparam int FB_WORDS      = 128;
    localparam int WORDS_PER_ROW = 32;
    localparam int ADDR_W        = 7;
    localparam int NPIX          = FB_WORDS * 8;
    localparam int LINE_PIX      = WORDS_PER_ROW * 8;
`ifdef FB_DOUBLE_BUFFER_EN
    localparam bit DOUBLE_BUF = 1'b1;
`else
    localparam bit DOUBLE_BUF = 1'b0;
`endif

    logic iClock = 1'b0;
    logic iReset;

    fb_scanout_if bus();

    fb_scanout #(
        .FB_WORDS(FB_WORDS),
        .WORDS_PER_ROW(WORDS_PER_ROW),
        .ADDR_W(ADDR_W)
    ) dut (
        .iClock(iClock),
        .iReset(iReset),
        .bus(bus)
    );

    always #5 iClock = ~iClock;

    int total = 0;
    int bad   = 0;

    task automatic checkValue(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Reference model: GPU-visible banks, the frame snapshot being shown,
    // and scan progress counted in pixels.
    int bank [2][FB_WORDS];
    int shown [FB_WORDS];
    int mSel = 0, mBusy = 0, mPending = 0, mCount = 0, mDone = 0, mPix = 0;
    int startAge = 99, donePulses = 0, scanSum = 0;
    int heldVld = 0, heldPix = 0;
    int readyMode = 0;
    int sumHist[$];
    int expPix, bi, wasBusy;
    bit lastX, fce;

    always @(negedge iClock) begin
        if (iReset) begin
            mBusy = 0; mPending = 0; mCount = 0; mDone = 0; mSel = 0;
            heldVld = 0; startAge = 99;
        end else begin
            checkValue("busy", int'(bus.oBusy), mBusy);
            checkValue("frame_done", int'(bus.oFrameDone), mDone);
            checkValue("frame_count", int'(bus.oFrameCount), mCount % 256);
            if (bus.oFrameDone) donePulses++;
            if (mBusy == 0)
                checkValue("idle_outputs", int'({bus.oPixelValid, bus.oFirstPixel, bus.oLineEnd}), 0);
            if (startAge == 1 || startAge == 2) checkValue("latency_early", int'(bus.oPixelValid), 0);
            if (startAge == 3) checkValue("latency_first", int'(bus.oPixelValid), 1);
            if (heldVld != 0) begin
                checkValue("hold_valid", int'(bus.oPixelValid), 1);
                checkValue("hold_pixel", int'(bus.oPixel), heldPix);
            end
            heldVld = 0;
            lastX = 1'b0;
            if (mBusy != 0 && bus.oPixelValid) begin
                if (bus.iPixelReady) begin
                    expPix = (shown[mPix / 8] >> (14 - 2 * (mPix % 8))) & 3;
                    checkValue("pixel", int'(bus.oPixel), expPix);
                    checkValue("first_pixel", int'(bus.oFirstPixel), int'(mPix == 0));
                    checkValue("line_end", int'(bus.oLineEnd), int'((mPix % LINE_PIX) == LINE_PIX - 1));
                    scanSum += int'(bus.oPixel) * (mPix % 13 + 1);
                    mPix++;
                    if (mPix == NPIX) lastX = 1'b1;
                end else begin
                    heldVld = 1;
                    heldPix = int'(bus.oPixel);
                end
            end
            fce = bus.iFrameBufferWe && (int'(bus.iFrameBufferAddr) == FB_WORDS - 1);
            if (bus.iFrameBufferWe && int'(bus.iFrameBufferAddr) < FB_WORDS) begin
                bi = DOUBLE_BUF ? 1 - mSel : 0;
                bank[bi][int'(bus.iFrameBufferAddr)] = int'(bus.iFrameBufferData);
            end
            wasBusy = mBusy;
            mDone = int'(lastX);
            if (lastX) begin
                mBusy = 0;
                mCount++;
                sumHist.push_back(scanSum);
            end
            if (wasBusy == 0 && (fce || mPending != 0)) begin
                mPending = 0;
                if (DOUBLE_BUF) mSel = 1 - mSel;
                for (int w = 0; w < FB_WORDS; w++) shown[w] = bank[mSel][w];
                mBusy = 1; mPix = 0; startAge = 0; scanSum = 0;
            end else if (fce) begin
                mPending = 1;
            end
            if (startAge < 99) startAge++;
        end
    end

    initial begin
        bus.iPixelReady = 1'b0;
        forever begin
            @(posedge iClock);
            #1;
            case (readyMode)
                0:       bus.iPixelReady = 1'b1;
                1:       bus.iPixelReady = ~bus.iPixelReady;
                default: bus.iPixelReady = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic writeWord(input logic [15:0] a, input logic [15:0] d);
        bus.iFrameBufferWe   = 1'b1;
        bus.iFrameBufferAddr = a;
        bus.iFrameBufferData = d;
        @(posedge iClock);
        #1;
        bus.iFrameBufferWe = 1'b0;
    endtask

    // kind 0: data = word index, 1: random, 2: constant val. Stops before word lastW+1.
    task automatic writeFrame(input int kind, input logic [15:0] val, input int lastW);
        logic [15:0] d;
        for (int w = 0; w <= lastW; w++) begin
            case (kind)
                0:       d = 16'(w);
                1:       d = 16'($urandom());
                default: d = val;
            endcase
            writeWord(16'(w), d);
        end
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n = 0;
        while ((mBusy != 0 || mPending != 0) && n < budget) begin
            @(posedge iClock);
            #1;
            n++;
        end
        checkValue({tag, "_timeout"}, int'(n >= budget), 0);
        repeat (3) @(posedge iClock);
        #1;
    endtask

    int d0, n, expSum;
    logic [15:0] lastData;

    initial begin
        iReset = 1'b1;
        bus.iFrameBufferWe = 1'b0;
        bus.iFrameBufferAddr = '0;
        bus.iFrameBufferData = '0;
        repeat (3) @(posedge iClock);
        #1;
        iReset = 1'b0;
        @(negedge iClock);
        checkValue("rst_valid", int'(bus.oPixelValid), 0);
        checkValue("rst_pixel", int'(bus.oPixel), 0);
        checkValue("rst_first", int'(bus.oFirstPixel), 0);
        checkValue("rst_line", int'(bus.oLineEnd), 0);
        checkValue("rst_busy", int'(bus.oBusy), 0);
        checkValue("rst_done", int'(bus.oFrameDone), 0);
        checkValue("rst_count", int'(bus.oFrameCount), 0);
        @(posedge iClock);
        #1;

        // Index-pattern frame, sink always ready.
        readyMode = 0;
        writeFrame(0, 16'h0, FB_WORDS - 1);
        waitIdle("scan1", 4000);
        checkValue("scan1_done_pulses", donePulses, 1);
        checkValue("scan1_count", int'(bus.oFrameCount), 1);

        // Same frame with ready toggling; checksum must match the first scan.
        readyMode = 1;
        writeFrame(0, 16'h0, FB_WORDS - 1);
        waitIdle("scan2", 8000);
        checkValue("scan2_count", int'(bus.oFrameCount), 2);
        checkValue("scan2_checksum", sumHist[1], sumHist[0]);

        // Random frame, random ready, three frame completions during the scan.
        readyMode = 2;
        writeFrame(1, 16'h0, FB_WORDS - 1);
        d0 = donePulses;
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(50, 300)) @(posedge iClock);
            #1;
            lastData = 16'(bank[DOUBLE_BUF ? 1 - mSel : 0][FB_WORDS - 1]);
            writeWord(16'(FB_WORDS - 1), lastData);
        end
        waitIdle("rescan", 12000);
        checkValue("rescan_done_pulses", donePulses - d0, 2);
        checkValue("rescan_count", int'(bus.oFrameCount), 4);

        // Reset in the middle of a scan.
        readyMode = 1;
        writeFrame(1, 16'h0, FB_WORDS - 1);
        n = 0;
        while (mPix < 1000 && n < 5000) begin
            @(posedge iClock);
            #1;
            n++;
        end
        checkValue("midscan_reach", int'(n >= 5000), 0);
        iReset = 1'b1;
        @(posedge iClock);
        #1;
        iReset = 1'b0;
        @(negedge iClock);
        checkValue("mrst_valid", int'(bus.oPixelValid), 0);
        checkValue("mrst_pixel", int'(bus.oPixel), 0);
        checkValue("mrst_first", int'(bus.oFirstPixel), 0);
        checkValue("mrst_line", int'(bus.oLineEnd), 0);
        checkValue("mrst_busy", int'(bus.oBusy), 0);
        d0 = donePulses;
        repeat (1500) @(posedge iClock);
        #1;
        checkValue("mrst_no_done", donePulses - d0, 0);
        checkValue("mrst_count", int'(bus.oFrameCount), 0);

        // Out-of-range writes must neither land in memory nor start a scan.
        readyMode = 2;
        writeFrame(1, 16'h0, FB_WORDS - 2);
        writeWord(16'h2000, 16'hA5A5);
        writeWord(16'h2000 | 16'(FB_WORDS - 1), 16'h5A5A);
        writeWord(16'(FB_WORDS) | 16'd3, 16'hFFFF);
        repeat (5) @(posedge iClock);
        #1;
        checkValue("oob_no_start", int'(bus.oBusy), 0);
        writeWord(16'(FB_WORDS - 1), 16'h1234);
        waitIdle("oob_scan", 8000);
        checkValue("oob_count", int'(bus.oFrameCount), 1);

`ifdef FB_DOUBLE_BUFFER_EN
        // Frame A (all 3s) shown while frame B (all 0s) is written behind it.
        readyMode = 0;
        writeFrame(2, 16'hFFFF, FB_WORDS - 1);
        writeFrame(2, 16'h0000, FB_WORDS - 1);
        waitIdle("dbuf", 8000);
        expSum = 0;
        for (int p = 0; p < NPIX; p++) expSum += 3 * (p % 13 + 1);
        checkValue("dbuf_scanA_sum", sumHist[sumHist.size() - 2], expSum);
        checkValue("dbuf_scanB_sum", sumHist[sumHist.size() - 1], 0);
        checkValue("dbuf_count", int'(bus.oFrameCount), 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
